// File: rtl/uart_tx_fsm_ctrl.sv
// UART transmit sequencer/serializer: frames a captured word as start, LSB-first data, optional parity, stop.
// Optional feature macro UART_TX_B2B_EN: a word offered during STOP is captured for a gapless next frame.
module uart_tx_fsm_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  PAR_BIT,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  ser_data_q, ser_data_d;
  logic [1:0]            mux_sel_q, mux_sel_d;
  logic                  busy_q, busy_d;
  logic                  capture_s;

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    ser_data_d = ser_data_q;
    mux_sel_d  = SEL_STOP;
    busy_d     = 1'b0;
    capture_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          capture_s = 1'b1;
          state_d   = S_START;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_START: begin
        state_d    = S_DATA;
        cnt_d      = '0;
        ser_data_d = shift_q[0];
        shift_d    = shift_q >> 1;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          state_d    = S_DATA;
          cnt_d      = cnt_q + CNT_ONE;
          ser_data_d = shift_q[0];
          shift_d    = shift_q >> 1;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
`ifdef UART_TX_B2B_EN
        if (DATA_VALID) begin
          capture_s = 1'b1;
          state_d   = S_START;
        end else begin
          state_d   = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Parity is taken from the word being captured so it is valid from the START cycle on
    if (capture_s) begin
      shift_d   = P_DATA;
      par_en_d  = PAR_EN;
      par_bit_d = parity_f(P_DATA, PAR_TYP);
    end else begin
      par_bit_d = par_bit_q;
    end

    case (state_d)
      S_IDLE:   begin mux_sel_d = SEL_STOP;   busy_d = 1'b0; end
      S_START:  begin mux_sel_d = SEL_START;  busy_d = 1'b1; end
      S_DATA:   begin mux_sel_d = SEL_DATA;   busy_d = 1'b1; end
      S_PARITY: begin mux_sel_d = SEL_PARITY; busy_d = 1'b1; end
      S_STOP:   begin mux_sel_d = SEL_STOP;   busy_d = 1'b1; end
      default:  begin mux_sel_d = SEL_STOP;   busy_d = 1'b0; end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      ser_data_q <= 1'b1;
      mux_sel_q  <= SEL_STOP;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      ser_data_q <= ser_data_d;
      mux_sel_q  <= mux_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign mux_sel  = mux_sel_q;
  assign ser_data = ser_data_q;
  assign PAR_BIT  = par_bit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm_ctrl.sv
// Self-checking bench for uart_tx_fsm_ctrl: directed frames, ignored input, mid-frame reset,
// back-to-back frames (gap depends on UART_TX_B2B_EN) and random frames against a frame model.
module tb_uart_tx_fsm_ctrl;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         PAR_BIT;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_mux[$];
  int exp_ser[$];

  always #5 CLK = ~CLK;

  uart_tx_fsm_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .mux_sel(mux_sel),
    .ser_data(ser_data), .PAR_BIT(PAR_BIT), .busy(busy)
  );

  // Frame model: one entry per busy cycle; exp_ser is -1 where the data line is don't-care
  task automatic model_frame(input logic [W-1:0] d, input logic pe);
    exp_mux.delete();
    exp_ser.delete();
    exp_mux.push_back(0); exp_ser.push_back(-1);
    for (int k = 0; k < W; k++) begin
      exp_mux.push_back(2);
      exp_ser.push_back(int'((d >> k) & 8'd1));
    end
    if (pe) begin
      exp_mux.push_back(3); exp_ser.push_back(-1);
    end
    exp_mux.push_back(1); exp_ser.push_back(-1);
  endtask

  function automatic logic model_parity(input logic [W-1:0] d, input logic odd);
    int ones = 0;
    for (int k = 0; k < W; k++) ones += int'(d[k]);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    #10;
    n_checks++; if (mux_sel !== 2'b01) begin n_errors++; $display("FAIL reset_mux got %b expected 01", mux_sel); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (ser_data !== 1'b1) begin n_errors++; $display("FAIL reset_ser got %b expected 1", ser_data); end
    n_checks++; if (PAR_BIT !== 1'b0) begin n_errors++; $display("FAIL reset_par got %b expected 0", PAR_BIT); end
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      n_checks++; if (busy !== 1'b0 || mux_sel !== 2'b01) begin n_errors++; $display("FAIL post_reset_idle got busy=%b mux=%b expected busy=0 mux=01", busy, mux_sel); end
    end
  endtask

  task automatic test_frame(input logic [W-1:0] d, input logic pe, input logic pt, input string tag);
    logic exp_par;
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    P_DATA = W'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    model_frame(d, pe);
    exp_par = model_parity(d, pt);
    for (int i = 0; i < exp_mux.size(); i++) begin
      n_checks++; if (mux_sel !== 2'(exp_mux[i])) begin n_errors++; $display("FAIL %s mux cycle %0d got %b expected %b", tag, i, mux_sel, 2'(exp_mux[i])); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL %s busy cycle %0d got %b expected 1", tag, i, busy); end
      if (exp_ser[i] >= 0) begin
        n_checks++; if (ser_data !== 1'(exp_ser[i])) begin n_errors++; $display("FAIL %s ser cycle %0d got %b expected %0d", tag, i, ser_data, exp_ser[i]); end
      end
      if (i > 0) begin
        n_checks++; if (PAR_BIT !== exp_par) begin n_errors++; $display("FAIL %s par cycle %0d got %b expected %b", tag, i, PAR_BIT, exp_par); end
      end
      @(negedge CLK);
    end
    n_checks++; if (busy !== 1'b0 || mux_sel !== 2'b01) begin n_errors++; $display("FAIL %s end_idle got busy=%b mux=%b expected busy=0 mux=01", tag, busy, mux_sel); end
    n_checks++; if (ser_data !== d[W-1]) begin n_errors++; $display("FAIL %s ser_hold got %b expected %b", tag, ser_data, d[W-1]); end
    n_checks++; if (PAR_BIT !== exp_par) begin n_errors++; $display("FAIL %s par_hold got %b expected %b", tag, PAR_BIT, exp_par); end
  endtask

  task automatic test_ignore_dv();
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    model_frame(8'h3C, 1'b0);
    for (int i = 0; i < exp_mux.size(); i++) begin
      n_checks++; if (mux_sel !== 2'(exp_mux[i]) || busy !== 1'b1) begin n_errors++; $display("FAIL ignore mux/busy cycle %0d got %b/%b expected %b/1", i, mux_sel, busy, 2'(exp_mux[i])); end
      if (exp_ser[i] >= 0) begin
        n_checks++; if (ser_data !== 1'(exp_ser[i])) begin n_errors++; $display("FAIL ignore ser cycle %0d got %b expected %0d", i, ser_data, exp_ser[i]); end
      end
      if (i == 3) begin
        DATA_VALID = 1'b1; P_DATA = 8'hFF;
      end else begin
        DATA_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    repeat (3) begin
      n_checks++; if (busy !== 1'b0 || mux_sel !== 2'b01) begin n_errors++; $display("FAIL ignore no_second_frame got busy=%b mux=%b expected busy=0 mux=01", busy, mux_sel); end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK);
    P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    n_checks++; if (mux_sel !== 2'b10 || PAR_BIT !== 1'b1) begin n_errors++; $display("FAIL midrst pre got mux=%b par=%b expected mux=10 par=1", mux_sel, PAR_BIT); end
    #2;
    RST = 1'b0;
    #1;
    n_checks++; if (mux_sel !== 2'b01) begin n_errors++; $display("FAIL midrst_mux got %b expected 01", mux_sel); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
    n_checks++; if (ser_data !== 1'b1) begin n_errors++; $display("FAIL midrst_ser got %b expected 1", ser_data); end
    n_checks++; if (PAR_BIT !== 1'b0) begin n_errors++; $display("FAIL midrst_par got %b expected 0", PAR_BIT); end
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      n_checks++; if (busy !== 1'b0 || mux_sel !== 2'b01) begin n_errors++; $display("FAIL midrst_stays_idle got busy=%b mux=%b expected busy=0 mux=01", busy, mux_sel); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    @(negedge CLK);
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hAA;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h55 : 8'hAA;
      if (f == 1) begin
`ifndef UART_TX_B2B_EN
        n_checks++; if (busy !== 1'b0 || mux_sel !== 2'b01) begin n_errors++; $display("FAIL b2b gap got busy=%b mux=%b expected busy=0 mux=01", busy, mux_sel); end
        @(negedge CLK);
`endif
      end
      model_frame(d, 1'b0);
      for (int i = 0; i < exp_mux.size(); i++) begin
        n_checks++; if (mux_sel !== 2'(exp_mux[i]) || busy !== 1'b1) begin n_errors++; $display("FAIL b2b frame %0d cycle %0d got mux=%b busy=%b expected mux=%b busy=1", f, i, mux_sel, busy, 2'(exp_mux[i])); end
        if (exp_ser[i] >= 0) begin
          n_checks++; if (ser_data !== 1'(exp_ser[i])) begin n_errors++; $display("FAIL b2b ser frame %0d cycle %0d got %b expected %0d", f, i, ser_data, exp_ser[i]); end
        end
        if (f == 1 && i == 0) DATA_VALID = 1'b0;
        @(negedge CLK);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b end got busy=%b expected 0", busy); end
  endtask

  task automatic test_random(input int n);
    for (int j = 0; j < n; j++) begin
      test_frame(W'($urandom), 1'($urandom), 1'($urandom), "rand");
    end
  endtask

  initial begin
    P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    test_reset();
    test_frame(8'h01, 1'b0, 1'b0, "t01");
    test_frame(8'hA5, 1'b1, 1'b0, "a5_even");
    test_frame(8'hA5, 1'b1, 1'b1, "a5_odd");
    test_frame(8'h07, 1'b1, 1'b1, "07_odd");
    test_ignore_dv();
    test_reset_mid_frame();
    test_frame(8'hC3, 1'b1, 1'b0, "after_rst");
    test_back_to_back();
    test_random(24);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
